// File: rtl/pipe_credit_fifo_if.sv
// Handshake bundle between an upstream fixed-latency pipeline, its producer and the downstream consumer.
// The slave side is the credit FIFO. The master side is the producer/pipeline/consumer environment.
interface pipe_credit_fifo_if #(
    parameter int DATA_W   = 32,
    parameter int STATUS_W = 1
);
    logic                issue_i;
    logic                issue_ok_o;
    logic                in_valid_i;
    logic [DATA_W-1:0]   data_i;
    logic [STATUS_W-1:0] status_i;
    logic                valid_o;
    logic                ready_i;
    logic [DATA_W-1:0]   data_o;
    logic [STATUS_W-1:0] status_o;

    modport slave (
        input  issue_i, in_valid_i, data_i, status_i, ready_i,
        output issue_ok_o, valid_o, data_o, status_o
    );

    modport master (
        output issue_i, in_valid_i, data_i, status_i, ready_i,
        input  issue_ok_o, valid_o, data_o, status_o
    );
endinterface

// File: rtl/pipe_credit_fifo.sv
// Credit-gated output FIFO behind a no-backpressure pipeline; sticky flags for protocol errors.
// Latency: write at edge N is visible on valid_o/data_o after edge N (1 cycle, no fall-through).
// Backpressure: consumer stalls via ready_i; producer is throttled by issue_ok_o credits.
module pipe_credit_fifo #(
    parameter  int DATA_W     = 32,
    parameter  int STATUS_W   = 1,
    parameter  int DEPTH      = 8,
    parameter  int PIPE_DEPTH = 1,
    localparam int AW         = $clog2(DEPTH),
    localparam int CW         = AW + 1,
    localparam int FW         = $clog2(PIPE_DEPTH + DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_credit_fifo_if.slave    bus,
    output logic [CW-1:0]        count_o,
    output logic [FW-1:0]        in_flight_o,
    output logic                 overflow_o,
    output logic                 unexpected_o,
    output logic                 credit_err_o
);
    localparam int OW = FW + 1;
    localparam int EW = DATA_W + STATUS_W;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [FW-1:0] in_flight_q, in_flight_d;
    logic          overflow_q, overflow_d;
    logic          unexpected_q, unexpected_d;
    logic          credit_err_q, credit_err_d;

    logic          pop, push, full, issue_ok, issue_acc, arr;
    logic [OW-1:0] occupancy;

    assign full      = (count_q == CW'(DEPTH));
    assign pop       = (count_q != '0) && bus.ready_i;
    assign push      = bus.in_valid_i && (!full || pop);
    // Credits come from registered state only, so a same-cycle pop frees a slot one cycle later.
    assign occupancy = OW'(count_q) + OW'(in_flight_q);
    assign issue_ok  = rst && (occupancy < OW'(DEPTH));
    assign issue_acc = bus.issue_i && issue_ok;
    assign arr       = bus.in_valid_i && (in_flight_q != '0);

    always_comb begin
        wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d      = count_q + CW'(push) - CW'(pop);
        in_flight_d  = in_flight_q;
        if (issue_acc && !arr) begin
            in_flight_d = in_flight_q + FW'(1);
        end else if (!issue_acc && arr) begin
            in_flight_d = in_flight_q - FW'(1);
        end
        overflow_d   = overflow_q   || (bus.in_valid_i && !push);
        unexpected_d = unexpected_q || (bus.in_valid_i && (in_flight_q == '0));
        credit_err_d = credit_err_q || (bus.issue_i && !issue_ok);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            in_flight_q  <= '0;
            overflow_q   <= 1'b0;
            unexpected_q <= 1'b0;
            credit_err_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            in_flight_q  <= in_flight_d;
            overflow_q   <= overflow_d;
            unexpected_q <= unexpected_d;
            credit_err_q <= credit_err_d;
        end
    end

    // Payload storage carries no reset; the head is only meaningful while valid_o is high.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.status_i, bus.data_i};
        end
    end

    assign {bus.status_o, bus.data_o} = mem_q[rd_ptr_q];
    assign bus.valid_o                = (count_q != '0);
    assign bus.issue_ok_o             = issue_ok;
    assign count_o                    = count_q;
    assign in_flight_o                = in_flight_q;
    assign overflow_o                 = overflow_q;
    assign unexpected_o               = unexpected_q;
    assign credit_err_o               = credit_err_q;
endmodule

// File: tb/tb_pipe_credit_fifo.sv
// Bench for pipe_credit_fifo: queue-based reference model checked every cycle, plus directed literal checks.
module tb_pipe_credit_fifo;
    localparam int DEPTH      = 8;
    localparam int PIPE_DEPTH = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] count;
    logic [4:0] in_flight;
    logic       ovf, unexp, cerr;

    pipe_credit_fifo_if #(.DATA_W(32), .STATUS_W(1)) bus();

    pipe_credit_fifo #(.DATA_W(32), .STATUS_W(1), .DEPTH(DEPTH), .PIPE_DEPTH(PIPE_DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .count_o      (count),
        .in_flight_o  (in_flight),
        .overflow_o   (ovf),
        .unexpected_o (unexp),
        .credit_err_o (cerr)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: stored items as a queue, in-flight as an integer, sticky flags as bits.
    logic [32:0] mq[$];
    int          m_infl = 0;
    bit          m_ovf = 0, m_unexp = 0, m_cerr = 0;

    function automatic bit m_ok();
        return (mq.size() + m_infl) < DEPTH;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (rst !== 1'b1) begin
                mq.delete();
                m_infl  = 0;
                m_ovf   = 0;
                m_unexp = 0;
                m_cerr  = 0;
            end else begin
                bit ok, pop, full, acc, arr;
                ok   = m_ok();
                pop  = (mq.size() != 0) && bus.ready_i;
                full = (mq.size() == DEPTH);
                acc  = bus.issue_i && ok;
                arr  = bus.in_valid_i && (m_infl != 0);
                if (bus.issue_i && !ok) m_cerr = 1;
                if (bus.in_valid_i && m_infl == 0) m_unexp = 1;
                if (pop) void'(mq.pop_front());
                if (bus.in_valid_i) begin
                    if (!full || pop) mq.push_back({bus.status_i, bus.data_i});
                    else m_ovf = 1;
                end
                m_infl = m_infl + int'(acc) - int'(arr);
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && chk_en) begin
                chk("cmp_valid", bus.valid_o, mq.size() != 0);
                chk("cmp_count", count, mq.size());
                chk("cmp_in_flight", in_flight, m_infl);
                chk("cmp_issue_ok", bus.issue_ok_o, m_ok());
                chk("cmp_overflow", ovf, m_ovf);
                chk("cmp_unexpected", unexp, m_unexp);
                chk("cmp_credit_err", cerr, m_cerr);
                if (mq.size() != 0) begin
                    chk("cmp_data", bus.data_o, mq[0][31:0]);
                    chk("cmp_status", bus.status_o, mq[0][32]);
                end
            end
        end
    end

    // Upstream pipeline emulation: an accepted issue emerges PIPE_DEPTH cycles later.
    bit          pv[PIPE_DEPTH];
    logic [31:0] pd[PIPE_DEPTH];
    logic [31:0] nd;
    logic [31:0] popped[$];

    task automatic clear_pipe();
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            pv[i] = 0;
            pd[i] = '0;
        end
        bus.issue_i    = 0;
        bus.in_valid_i = 0;
        bus.data_i     = '0;
        bus.status_i   = '0;
        bus.ready_i    = 0;
    endtask

    task automatic step(input bit want, input bit rdy, input bit fv, input logic [31:0] fd, input bit raw);
        logic [31:0] d;
        bit          acc;
        @(negedge clk);
        #1;
        d              = fv ? fd : pd[PIPE_DEPTH-1];
        bus.in_valid_i = pv[PIPE_DEPTH-1] | fv;
        bus.data_i     = d;
        bus.status_i   = ^d;
        acc            = want && m_ok();
        bus.issue_i    = acc | raw;
        bus.ready_i    = rdy;
        for (int i = PIPE_DEPTH - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = acc;
        pd[0] = nd;
        if (acc) nd = nd + 1;
        #1;
        if (bus.valid_o && bus.ready_i) popped.push_back(bus.data_o);
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) step(0, rdy, 0, 32'h0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 0;
        clear_pipe();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_issue_ok_low", bus.issue_ok_o, 0);
        rst = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        rst = 0;
        nd  = '0;
        clear_pipe();

        // 1: reset then idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("t1_issue_ok_in_reset", bus.issue_ok_o, 0);
        chk("t1_valid_in_reset", bus.valid_o, 0);
        rst    = 1;
        chk_en = 1;
        idle(1, 0);
        chk("t1_valid", bus.valid_o, 0);
        chk("t1_count", count, 0);
        chk("t1_in_flight", in_flight, 0);
        chk("t1_issue_ok", bus.issue_ok_o, 1);
        chk("t1_flags", {ovf, unexp, cerr}, 0);

        // 2: credit exhaustion with consumer stalled
        nd = 32'h10;
        repeat (14) step(1, 0, 0, 32'h0, 0);
        chk("t2_count", count, 8);
        chk("t2_issue_ok", bus.issue_ok_o, 0);
        chk("t2_in_flight", in_flight, 0);
        chk("t2_accepted", nd, 32'h18);
        chk("t2_overflow", ovf, 0);
        chk("t2_credit_err", cerr, 0);

        // 3: ordering and pointer wrap under random ready
        idle(10, 1);
        popped.delete();
        nd  = 32'h100;
        cyc = 0;
        while (!(nd == 32'h114 && mq.size() == 0 && m_infl == 0 && !pv[0] && !pv[1] && !pv[2]) && cyc < 3000) begin
            step((nd < 32'h114) && ($urandom_range(3) != 0), 1'($urandom_range(1)), 0, 32'h0, 0);
            cyc++;
        end
        chk("t3_timeout", cyc < 3000, 1);
        chk("t3_popped_count", popped.size(), 20);
        for (int i = 0; i < popped.size() && i < 20; i++) chk("t3_order", popped[i], 32'h100 + i);
        chk("t3_flags", {ovf, unexp, cerr}, 0);

        // 4: full with simultaneous push/pop, then full without pop
        nd = 32'h20;
        repeat (12) step(1, 0, 0, 32'h0, 0);
        chk("t4_full", count, 8);
        step(0, 1, 1, 32'hAA, 0);
        idle(1, 0);
        chk("t4_count_after_pushpop", count, 8);
        chk("t4_overflow_clear", ovf, 0);
        chk("t4_unexpected", unexp, 1);
        step(0, 0, 1, 32'hAB, 0);
        idle(1, 0);
        chk("t4_count_after_drop", count, 8);
        chk("t4_overflow_set", ovf, 1);
        popped.delete();
        idle(10, 1);
        chk("t4_drain_count", popped.size(), 8);
        if (popped.size() == 8) begin
            chk("t4_first_after_pop", popped[0], 32'h21);
            chk("t4_tail_aa", popped[7], 32'hAA);
        end

        // 5: protocol errors
        do_reset();
        step(0, 0, 1, 32'h55, 0);
        idle(1, 0);
        chk("t5_unexpected", unexp, 1);
        chk("t5_count", count, 1);
        chk("t5_in_flight_zero", in_flight, 0);
        chk("t5_credit_err_clear", cerr, 0);
        nd = 32'h60;
        repeat (7) step(1, 0, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 1);
        idle(1, 0);
        chk("t5_credit_err", cerr, 1);
        chk("t5_overflow_clear", ovf, 0);
        idle(6, 0);
        chk("t5_count_full", count, 8);

        // 6: asynchronous reset mid-operation
        do_reset();
        nd = 32'h40;
        repeat (12) step(1, 0, 0, 32'h0, 0);
        step(0, 0, 1, 32'hEE, 0);
        idle(3, 1);
        step(1, 0, 0, 32'h0, 0);
        step(1, 0, 0, 32'h0, 0);
        idle(1, 0);
        chk("t6_pre_count", count, 5);
        chk("t6_pre_in_flight", in_flight, 2);
        chk("t6_pre_overflow", ovf, 1);
        #1;
        rst = 0;
        #1;
        chk("t6_count", count, 0);
        chk("t6_in_flight", in_flight, 0);
        chk("t6_flags", {ovf, unexp, cerr}, 0);
        chk("t6_valid", bus.valid_o, 0);
        chk("t6_issue_ok", bus.issue_ok_o, 0);
        clear_pipe();
        repeat (2) @(negedge clk);
        #1;
        rst = 1;
        idle(3, 0);
        chk("t6_post_issue_ok", bus.issue_ok_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
